// File: rtl/ram_dp_param.sv
// Simple dual-port RAM with per-byte write enables, selectable read-during-write,
// optional output register and a clear sweep that runs after reset or on request.
// state   | meaning
// S_CLEAR | sweeping CLR_VAL into every word, user requests ignored
// S_IDLE  | accepting one write and one read per cycle
module ram_dp_param #(
  parameter int unsigned       DATA_W  = 8,
  parameter int unsigned       ADDR_W  = 5,
  parameter int unsigned       DEPTH   = 32,
  parameter bit                RDW_NEW = 1'b0,
  parameter bit                OUT_REG = 1'b0,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_clr,
  output logic                o_busy,
  input  logic                i_write,
  input  logic [ADDR_W-1:0]   i_addr_wr,
  input  logic [DATA_W/8-1:0] i_be,
  input  logic [DATA_W-1:0]   i_data,
  input  logic                i_read,
  input  logic [ADDR_W-1:0]   i_addr_r,
  output logic [DATA_W-1:0]   o_data,
  output logic                o_valid
);

  localparam int              NB      = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);

  typedef enum logic {S_CLEAR, S_IDLE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              clr_we, acc;
  logic              wr_hit, rd_acc, rd_in;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    clr_we  = 1'b0;
    acc     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        clr_we = 1'b1;
        ptr_d  = ptr_q + 1'b1;
        if (ptr_q == LAST) begin
          state_d = S_IDLE;
          ptr_d   = '0;
        end
      end
      S_IDLE: begin
        if (i_clr) begin
          state_d = S_CLEAR;
          ptr_d   = '0;
        end else begin
          acc = 1'b1;
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  assign wr_hit = acc & i_write & ({1'b0, i_addr_wr} < DEPTH_X);
  assign rd_acc = acc & i_read;
  assign rd_in  = ({1'b0, i_addr_r} < DEPTH_X);

  // Out-of-range reads return zero; same-address new-data lanes bypass the array.
  always_comb begin
    rd_word = '0;
    if (rd_in) rd_word = mem[i_addr_r];
    if (RDW_NEW && wr_hit && (i_addr_wr == i_addr_r)) begin
      for (int k = 0; k < NB; k++) begin
        if (i_be[k]) rd_word[8*k +: 8] = i_data[8*k +: 8];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst_n) begin
      if (clr_we) begin
        mem[ptr_q] <= CLR_VAL;
      end else if (wr_hit) begin
        for (int k = 0; k < NB; k++) begin
          if (i_be[k]) mem[i_addr_wr][8*k +: 8] <= i_data[8*k +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_CLEAR;
      ptr_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= rd_word;
    end
  end

  generate
    if (OUT_REG) begin : g_out_reg
      logic [DATA_W-1:0] out_data_q;
      logic              out_valid_q;
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          out_valid_q <= 1'b0;
          out_data_q  <= '0;
        end else begin
          out_valid_q <= rd_valid_q;
          if (rd_valid_q) out_data_q <= rd_data_q;
        end
      end
      assign o_data  = out_data_q;
      assign o_valid = out_valid_q;
    end else begin : g_no_out_reg
      assign o_data  = rd_data_q;
      assign o_valid = rd_valid_q;
    end
  endgenerate

  assign o_busy = (state_q == S_CLEAR);

endmodule
